fft_frame_sched: RTL and testbench
==================================

Name: fft_frame_sched

Overview:
- Frame scheduler that shares one streaming FFT core among NREQ requesters.
- Grants whole N-sample frames round-robin and drives the core's di_en/di_re/di_im inputs.
- Holds a FIFO of owner tags for frames in flight inside the core.
- Routes each N-sample do_* result frame back to the owner of the oldest outstanding input frame.

Parameters:
N, 1024, FFT points per frame; power of two, at least 4
WIDTH, 32, bit width of the real part and of the imaginary part
NREQ, 4, number of requesters, 2 to 8
MAX_INFLIGHT, 2, maximum frames accepted into the core but not yet fully output; 1 to 4

Ports:
clock  in  1  single clock; all logic on its rising edge
reset  in  1  synchronous, active-high; clears all state
req_valid  in  NREQ  per-requester sample valid
req_ready  out  NREQ  per-requester sample accept; at most one bit set
req_re  in  NREQ*WIDTH  packed real samples; requester k occupies bits [k*WIDTH +: WIDTH]
req_im  in  NREQ*WIDTH  packed imaginary samples, same packing
di_en  out  1  FFT input sample enable
di_re  out  WIDTH  FFT input real
di_im  out  WIDTH  FFT input imaginary
do_en  in  1  FFT output sample enable
do_re  in  WIDTH  FFT output real
do_im  in  WIDTH  FFT output imaginary
res_valid  out  NREQ  one-hot result valid, addressed to the frame owner
res_re  out  WIDTH  result real, shared by all requesters
res_im  out  WIDTH  result imaginary, shared by all requesters
res_last  out  1  marks the N-th result sample of a frame
res_id  out  clog2(NREQ)  owner of the current result sample
busy  out  1  high when a frame is streaming or any frame is in flight
err_orphan  out  1  sticky; set when do_en arrives while the tag FIFO is empty

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; sample counters 0; tag FIFO empty; inflight count 0; round-robin pointer set so requester 0 has top priority.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - If any req_valid is set and inflight < MAX_INFLIGHT, pick the first requester with valid set, searching from (last_grant+1) mod NREQ.
  - Register the pick as gnt, set last_grant = gnt, go to STREAM. No samples are accepted in this cycle.
  - Grant latency: one cycle from req_valid to req_ready.
- STREAM:
  - req_ready[gnt] = 1, combinational from the state; all other ready bits are 0.
  - An accepted beat is a cycle with req_valid[gnt] = 1.
  - On each accepted beat: register di_en=1, di_re/di_im = slice gnt of req_re/req_im, and increment the input counter.
  - Cycles without an accepted beat register di_en=0 and hold di_re/di_im. Gaps inside a frame are legal.
  - Input path latency: exactly 1 cycle from acceptance to di_*.
- Frame end: on accepted beat N (counter == N-1), push gnt into the tag FIFO, increment inflight, clear the counter, return to IDLE.
  - A new grant needs at least one IDLE cycle, so consecutive frames are separated by at least one idle beat.
- Input frames are never truncated. A requester that drops valid mid-frame keeps the grant until it finishes the frame.
- Output path:
  - On each do_en, register res_valid = one-hot(tag FIFO head), res_re/res_im = do_re/do_im, res_id = head, and increment the output counter.
  - Output path latency: 1 cycle.
  - res_last = 1 on output beat N. In that same cycle, pop the FIFO, decrement inflight, clear the output counter.
  - Results cannot be back-pressured; requesters must always accept them.
- Push and pop in the same cycle leave inflight unchanged. FIFO depth is MAX_INFLIGHT; the admission check guarantees no overflow.
- do_en with an empty FIFO: set err_orphan (cleared only by reset), keep res_valid=0, do not advance the output counter.
- busy = (state == STREAM) or (inflight != 0).
- Reset mid-operation: the partial frame is discarded and all tags are dropped. The FFT core shares the same reset.
- Widths:
  - Input and output counters are clog2(N) bits.
  - inflight is clog2(MAX_INFLIGHT+1) bits.
  - Counter wrap is explicit at N-1, with no reliance on natural overflow.

Decomposition:
- Package fft_sched_pkg holds:
  - the clog2 constant function
  - the state enum (IDLE, STREAM)
  - localparams for counter, id and inflight widths.
- One sub-module, fft_tag_fifo: a synchronous FIFO of clog2(NREQ)-bit tags with push, pop, head, empty and full.
  - Simultaneous push and pop must be legal when non-empty.
  - It is instantiated once.

Test Plan:
- N=16, NREQ=4. Requester 2 sends 16 contiguous samples with re=k, im=0.
  - Expect req_ready[2] one cycle after valid, 16 di_en beats with di_re 0..15 delayed by one cycle, inflight 1.
  - A 16-beat model FFT response yields res_valid=4'b0100, res_last on beat 16, busy dropping after it.
- Requesters 0 and 1 both valid from reset.
  - Expect grant order 0, 1, 0, 1 over four frames.
  - Requester 1 must be granted on the IDLE cycle right after frame 0 completes.
- Requester 0 valid pattern 1,0,0,1 repeating.
  - Expect exactly 16 di_en pulses and no grant change before the 16th accept, even with requester 3 also requesting.
- MAX_INFLIGHT=2 with the model FFT holding outputs.
  - After two frames, a third request stays unready.
  - Once the first result frame's res_last fires, the grant follows in the next cycle.
- Assert reset on input beat 7 of a frame.
  - Next cycle: req_ready=0, di_en=0, busy=0, FIFO empty.
  - A fresh frame afterwards completes normally.
- Drive do_en with no frame in flight.
  - Expect err_orphan=1 and res_valid=0; err_orphan stays set until reset.

Source files
------------

// File: rtl/fft_sched_pkg.sv
// Shared types and width helpers for the FFT frame scheduler.
package fft_sched_pkg;

  // Ceiling log2 with a floor of 1 so single-entry structures still get a real bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Round-robin search order: offset i after the previous grant, modulo nreq.
  function automatic int rr_next(input int last, input int offset, input int nreq);
    return (last + 1 + offset) % nreq;
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } sched_state_e;

  localparam int DEF_N            = 1024;
  localparam int DEF_NREQ         = 4;
  localparam int DEF_MAX_INFLIGHT = 2;
  localparam int DEF_CNT_W        = clog2(DEF_N);
  localparam int DEF_ID_W         = clog2(DEF_NREQ);
  localparam int DEF_IF_W         = clog2(DEF_MAX_INFLIGHT + 1);

endpackage

// File: rtl/fft_tag_fifo.sv
// Owner-tag FIFO for frames in flight inside the FFT core; push and pop may coincide.
module fft_tag_fifo
  import fft_sched_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot being written when full.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Shares one streaming FFT core among NREQ requesters, granting whole frames round-robin
// and steering each result frame back to the owner of the oldest frame in flight.
//
//   state  | meaning
//   IDLE   | no frame streaming; picks next requester if the core has room
//   STREAM | granted requester feeds samples until N beats have been accepted
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int N            = 1024,
  parameter int WIDTH        = 32,
  parameter int NREQ         = 4,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_re,
  input  logic [NREQ*WIDTH-1:0]   req_im,
  output logic                    di_en,
  output logic [WIDTH-1:0]        di_re,
  output logic [WIDTH-1:0]        di_im,
  input  logic                    do_en,
  input  logic [WIDTH-1:0]        do_re,
  input  logic [WIDTH-1:0]        do_im,
  output logic [NREQ-1:0]         res_valid,
  output logic [WIDTH-1:0]        res_re,
  output logic [WIDTH-1:0]        res_im,
  output logic                    res_last,
  output logic [clog2(NREQ)-1:0]  res_id,
  output logic                    busy,
  output logic                    err_orphan
);

  localparam int CNT_W = clog2(N);
  localparam int ID_W  = clog2(NREQ);
  localparam int IF_W  = clog2(MAX_INFLIGHT + 1);

  sched_state_e     state;
  sched_state_e     state_nxt;
  logic [ID_W-1:0]  gnt;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  pick_idx;
  logic [ID_W-1:0]  cand;
  logic             pick_found;
  logic             admit_ok;
  logic             grant_now;
  logic             accept;
  logic             frame_end;

  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [IF_W-1:0]  inflight;

  logic [ID_W-1:0]  tag_head;
  logic             tag_empty;
  logic             tag_full;
  logic             out_beat;
  logic             out_last;
  logic             orphan;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ID_W'(rr_next(int'(last_grant), i, NREQ));
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Tag FIFO fullness mirrors inflight; both guard admission.
  assign admit_ok  = (inflight < IF_W'(MAX_INFLIGHT)) && !tag_full;
  assign grant_now = (state == IDLE) && pick_found && admit_ok;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (grant_now) state_nxt = STREAM;
      end
      STREAM: begin
        req_ready[gnt] = 1'b1;
        accept         = req_valid[gnt];
        frame_end      = accept && (in_cnt == CNT_W'(N - 1));
        if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Requester 0 leads after reset because the search starts just past NREQ-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt        <= '0;
      last_grant <= ID_W'(NREQ - 1);
    end else if (grant_now) begin
      gnt        <= pick_idx;
      last_grant <= pick_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      di_en  <= 1'b0;
      di_re  <= '0;
      di_im  <= '0;
      in_cnt <= '0;
    end else begin
      di_en <= accept;
      if (accept) begin
        di_re  <= req_re[int'(gnt)*WIDTH +: WIDTH];
        di_im  <= req_im[int'(gnt)*WIDTH +: WIDTH];
        in_cnt <= frame_end ? '0 : in_cnt + CNT_W'(1);
      end
    end
  end

  assign out_beat = do_en && !tag_empty;
  assign out_last = out_beat && (out_cnt == CNT_W'(N - 1));
  assign orphan   = do_en && tag_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      res_valid  <= '0;
      res_re     <= '0;
      res_im     <= '0;
      res_last   <= 1'b0;
      res_id     <= '0;
      out_cnt    <= '0;
      err_orphan <= 1'b0;
    end else begin
      res_valid <= out_beat ? (NREQ'(1) << tag_head) : '0;
      res_last  <= out_last;
      if (out_beat) begin
        res_re  <= do_re;
        res_im  <= do_im;
        res_id  <= tag_head;
        out_cnt <= out_last ? '0 : out_cnt + CNT_W'(1);
      end
      if (orphan) err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({frame_end, out_last})
        2'b10:   inflight <= inflight + IF_W'(1);
        2'b01:   inflight <= inflight - IF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = (state == STREAM) || (inflight != '0);

  fft_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .TAG_W (ID_W)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (frame_end),
    .push_tag (gnt),
    .pop      (out_last),
    .head     (tag_head),
    .empty    (tag_empty),
    .full     (tag_full)
  );

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: scoreboarded di_* and res_* streams plus grant-order,
// admission, mid-frame reset and orphan-output checks.
module tb_fft_frame_sched;

  localparam int N     = 16;
  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int MAXF  = 2;

  logic                  clock;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_re;
  logic [NREQ*WIDTH-1:0] req_im;
  logic                  di_en;
  logic [WIDTH-1:0]      di_re;
  logic [WIDTH-1:0]      di_im;
  logic                  do_en;
  logic [WIDTH-1:0]      do_re;
  logic [WIDTH-1:0]      do_im;
  logic [NREQ-1:0]       res_valid;
  logic [WIDTH-1:0]      res_re;
  logic [WIDTH-1:0]      res_im;
  logic                  res_last;
  logic [1:0]            res_id;
  logic                  busy;
  logic                  err_orphan;

  fft_frame_sched #(
    .N            (N),
    .WIDTH        (WIDTH),
    .NREQ         (NREQ),
    .MAX_INFLIGHT (MAXF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_re     (req_re),
    .req_im     (req_im),
    .di_en      (di_en),
    .di_re      (di_re),
    .di_im      (di_im),
    .do_en      (do_en),
    .do_re      (do_re),
    .do_im      (do_im),
    .res_valid  (res_valid),
    .res_re     (res_re),
    .res_im     (res_im),
    .res_last   (res_last),
    .res_id     (res_id),
    .busy       (busy),
    .err_orphan (err_orphan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]       id;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    logic             last;
  } res_t;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [2*WIDTH-1:0] exp_di[$];
  res_t               exp_res[$];
  int                 model_tags[$];
  int                 gnt_log[$];
  int                 gnt_cyc[$];
  int                 gnt_di[$];
  int                 end_cyc[$];
  int                 sent[NREQ];
  int                 out_beat, frames_in, frames_out, di_count, salt, first_last_cyc;
  bit                 fft_go;
  logic [NREQ-1:0]    prev_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [2*WIDTH-1:0] e;
    res_t               r;
    logic [NREQ-1:0]    oh;
    @(posedge clock);
    #1;
    cyc++;
    check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
    if (di_en) begin
      di_count++;
      check("di_pending", 64'(exp_di.size() > 0), 64'd1);
      if (exp_di.size() > 0) begin
        e = exp_di.pop_front();
        check("di_data", {di_re, di_im}, e);
      end
    end
    if (res_valid != '0) begin
      check("res_pending", 64'(exp_res.size() > 0), 64'd1);
      if (exp_res.size() > 0) begin
        r  = exp_res.pop_front();
        oh = 4'b0001 << r.id;
        check("res_valid", res_valid, oh);
        check("res_id", res_id, r.id);
        check("res_data", {res_re, res_im}, {r.re, r.im});
        check("res_last", res_last, r.last);
      end
      if (res_last && first_last_cyc < 0) first_last_cyc = cyc;
    end else begin
      check("res_last_idle", res_last, 1'b0);
    end
    if (req_ready != '0 && prev_ready == '0) begin
      for (int k = 0; k < NREQ; k++) if (req_ready[k]) gnt_log.push_back(k);
      gnt_cyc.push_back(cyc);
      gnt_di.push_back(di_count);
    end
    prev_ready = req_ready;
  endtask

  task automatic step();
    logic [WIDTH-1:0] re, im;
    res_t             r;
    if (fft_go && model_tags.size() > 0) begin
      do_en  = 1'b1;
      do_re  = WIDTH'(16'h4000 + frames_out * 16 + out_beat);
      do_im  = WIDTH'(salt * 100 + out_beat);
      r.id   = 2'(model_tags[0]);
      r.re   = do_re;
      r.im   = do_im;
      r.last = (out_beat == N - 1);
      exp_res.push_back(r);
      out_beat++;
      if (out_beat == N) begin
        out_beat = 0;
        void'(model_tags.pop_front());
        frames_out++;
      end
    end else begin
      do_en = 1'b0;
    end
    for (int k = 0; k < NREQ; k++) begin
      re = WIDTH'(sent[k] + salt * k * 256);
      im = WIDTH'(salt * (k + 1));
      req_re[k*WIDTH +: WIDTH] = re;
      req_im[k*WIDTH +: WIDTH] = im;
      if (req_ready[k] && req_valid[k]) begin
        exp_di.push_back({re, im});
        sent[k]++;
        if (sent[k] == N) begin
          sent[k] = 0;
          model_tags.push_back(k);
          frames_in++;
          end_cyc.push_back(cyc + 1);
        end
      end
    end
    tick();
  endtask

  task automatic clear_model();
    exp_di.delete();
    exp_res.delete();
    model_tags.delete();
    gnt_log.delete();
    gnt_cyc.delete();
    gnt_di.delete();
    end_cyc.delete();
    for (int k = 0; k < NREQ; k++) sent[k] = 0;
    out_beat = 0; frames_in = 0; frames_out = 0; di_count = 0; first_last_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; do_en = 1'b0; fft_go = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    clear_model();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_re = '0; req_im = '0;
    do_en = 1'b0; do_re = '0; do_im = '0; prev_ready = '0;
    salt = 0; fft_go = 1'b0;
    clear_model();
    do_reset();

    // Reset state
    check("rst_ready", req_ready, 4'b0000);
    check("rst_di_en", di_en, 1'b0);
    check("rst_res_valid", res_valid, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_err_orphan", err_orphan, 1'b0);
    check("rst_res_id", res_id, 2'd0);

    // Single frame from requester 2, re = k, im = 0
    salt = 0;
    req_valid = 4'b0100;
    check("t1_ready_before", req_ready, 4'b0000);
    step();
    check("t1_grant_latency", req_ready, 4'b0100);
    for (int i = 0; i < 100 && frames_in < 1; i++) step();
    req_valid = '0;
    check("t1_frames_in", frames_in, 1);
    check("t1_di_count", di_count, N);
    check("t1_ready_after", req_ready, 4'b0000);
    check("t1_busy_inflight", busy, 1'b1);
    fft_go = 1'b1;
    for (int i = 0; i < 100 && frames_out < 1; i++) step();
    check("t1_frames_out", frames_out, 1);
    check("t1_busy_drop", busy, 1'b0);
    step();
    check("t1_res_drained", exp_res.size(), 0);

    // Requesters 0 and 1 contend: order 0,1,0,1 with a single idle cycle between frames
    do_reset();
    salt = 1; fft_go = 1'b1; req_valid = 4'b0011;
    for (int i = 0; i < 600 && frames_in < 4; i++) step();
    req_valid = '0;
    for (int i = 0; i < 200 && frames_out < 4; i++) step();
    check("t2_frames_out", frames_out, 4);
    check("t2_grants", gnt_log.size(), 4);
    if (gnt_log.size() >= 4) begin
      check("t2_order0", gnt_log[0], 0);
      check("t2_order1", gnt_log[1], 1);
      check("t2_order2", gnt_log[2], 0);
      check("t2_order3", gnt_log[3], 1);
    end
    if (gnt_cyc.size() >= 2 && end_cyc.size() >= 1)
      check("t2_regrant_cycle", gnt_cyc[1], end_cyc[0] + 1);
    check("t2_di_count", di_count, 4 * N);

    // Gappy requester 0 keeps the grant for all 16 beats despite requester 3
    do_reset();
    salt = 2; fft_go = 1'b1;
    for (int i = 0; i < 300 && frames_in < 2; i++) begin
      req_valid[0] = ((i % 4) == 0) || ((i % 4) == 3);
      req_valid[3] = 1'b1;
      step();
    end
    req_valid = '0;
    for (int i = 0; i < 200 && frames_out < 2; i++) step();
    check("t3_frames_out", frames_out, 2);
    check("t3_grants", gnt_log.size(), 2);
    if (gnt_log.size() >= 2) begin
      check("t3_first", gnt_log[0], 0);
      check("t3_second", gnt_log[1], 3);
      check("t3_di_before_switch", gnt_di[1], N);
    end

    // Admission limit: third frame waits for the first result frame to finish
    do_reset();
    salt = 3; fft_go = 1'b0; req_valid = 4'b0111;
    for (int i = 0; i < 200 && frames_in < 2; i++) step();
    check("t4_frames_in", frames_in, 2);
    for (int i = 0; i < 20; i++) begin
      step();
      check("t4_stall_ready", req_ready, 4'b0000);
    end
    check("t4_busy", busy, 1'b1);
    fft_go = 1'b1;
    for (int i = 0; i < 100 && first_last_cyc < 0; i++) step();
    step();
    check("t4_grants", gnt_log.size(), 3);
    if (gnt_log.size() >= 3) begin
      check("t4_third_owner", gnt_log[2], 2);
      check("t4_third_cycle", gnt_cyc[2], first_last_cyc + 1);
    end
    req_valid = 4'b0100;
    for (int i = 0; i < 100 && frames_in < 3; i++) step();
    req_valid = '0;
    for (int i = 0; i < 200 && frames_out < 3; i++) step();
    check("t4_frames_out", frames_out, 3);

    // Reset during input beat 7 discards the partial frame
    do_reset();
    salt = 4; fft_go = 1'b0; req_valid = 4'b0010;
    for (int i = 0; i < 50 && sent[1] < 7; i++) step();
    check("t5_beats_before_reset", sent[1], 7);
    reset = 1'b1;
    tick();
    check("t5_ready", req_ready, 4'b0000);
    check("t5_di_en", di_en, 1'b0);
    check("t5_busy", busy, 1'b0);
    reset = 1'b0;
    clear_model();
    req_valid = 4'b1000; fft_go = 1'b1;
    for (int i = 0; i < 200 && frames_out < 1; i++) begin
      if (frames_in >= 1) req_valid = '0;
      step();
    end
    check("t5_fresh_frame", frames_out, 1);
    check("t5_busy_after", busy, 1'b0);
    check("t5_orphan", err_orphan, 1'b0);

    // Output beat with nothing in flight
    do_reset();
    do_en = 1'b1; do_re = 16'h0bad; do_im = 16'h0bad;
    tick();
    check("t6_orphan_set", err_orphan, 1'b1);
    check("t6_no_res", res_valid, 4'b0000);
    do_en = 1'b0;
    tick(); tick(); tick();
    check("t6_orphan_sticky", err_orphan, 1'b1);
    salt = 5; fft_go = 1'b1; req_valid = 4'b0001;
    for (int i = 0; i < 200 && frames_out < 1; i++) begin
      if (frames_in >= 1) req_valid = '0;
      step();
    end
    check("t6_frame_after_orphan", frames_out, 1);
    check("t6_orphan_still", err_orphan, 1'b1);
    do_reset();
    check("t6_orphan_cleared", err_orphan, 1'b0);

    check("end_di_drained", exp_di.size(), 0);
    check("end_res_drained", exp_res.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
